mips_decode_stage: RTL

Registered, buffered successor to the combinational MIPS decoder. Accepts 32-bit instruction words over a valid/ready handshake, decodes opcode/funct into ALU control plus register/immediate fields, and queues decoded bundles in a parametrised FIFO ahead of the execute stage. It also keeps a saturating count of illegal instructions for the datapath's debug path.

---
 rtl/mips_decode_stage_if.sv | 34 +++
 rtl/mips_decode_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mips_decode_stage_if.sv
// Handshake bundle between the fetch side and execute side of mips_decode_stage.
// master = producer/consumer environment, slave = the decode stage itself.
interface mips_decode_stage_if #(
  parameter int TAG_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_alu_op;
  logic [1:0]       out_alu_src2;
  logic             out_rd_src;
  logic             out_writeenable;
  logic             out_except;
  logic [4:0]       out_rs;
  logic [4:0]       out_rt;
  logic [4:0]       out_rd;
  logic [15:0]      out_imm;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_alu_op, out_alu_src2, out_rd_src,
           out_writeenable, out_except, out_rs, out_rt, out_rd, out_imm, out_tag
  );

  modport slave (
    input  in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_alu_op, out_alu_src2, out_rd_src,
           out_writeenable, out_except, out_rs, out_rt, out_rd, out_imm, out_tag
  );
endinterface

// File: rtl/mips_decode_stage.sv
// Registered MIPS decoder: decodes at push and queues bundles in a DEPTH-entry FIFO.
// Optional macro DECODE_LUI_EN makes opcode 0x0f (lui) a legal instruction.
module mips_decode_stage #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  mips_decode_stage_if.slave   bus,
  output logic [CNT_W-1:0]     exc_count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  typedef enum logic [2:0] {
    ALU_NONE = 3'd0,
    ALU_ADD  = 3'd2,
    ALU_SUB  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_OR   = 3'd5,
    ALU_NOR  = 3'd6,
    ALU_XOR  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC2_RT   = 2'd0,
    SRC2_SIMM = 2'd1,
    SRC2_ZIMM = 2'd2,
    SRC2_UIMM = 2'd3
  } src2_e;

  typedef struct packed {
    alu_op_e          alu_op;
    src2_e            alu_src2;
    logic             rd_src;
    logic             we;
    logic             except;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [15:0]      imm;
    logic [TAG_W-1:0] tag;
  } bundle_t;

  bundle_t          mem [DEPTH];
  bundle_t          dec;
  bundle_t          head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic             push;
  logic             pop;

  logic             legal;
  alu_op_e          op_sel;
  src2_e            src2_sel;
  logic             rd_src_sel;
  logic [5:0]       opcode;
  logic [5:0]       funct;

  assign opcode = bus.in_inst[31:26];
  assign funct  = bus.in_inst[5:0];

  always_comb begin
    legal      = 1'b1;
    op_sel     = ALU_NONE;
    src2_sel   = SRC2_RT;
    rd_src_sel = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20:   op_sel = ALU_ADD;
          6'h22:   op_sel = ALU_SUB;
          6'h24:   op_sel = ALU_AND;
          6'h25:   op_sel = ALU_OR;
          6'h26:   op_sel = ALU_XOR;
          6'h27:   op_sel = ALU_NOR;
          default: legal  = 1'b0;
        endcase
      end
      6'h08: begin op_sel = ALU_ADD; src2_sel = SRC2_SIMM; rd_src_sel = 1'b1; end
      6'h0c: begin op_sel = ALU_AND; src2_sel = SRC2_ZIMM; rd_src_sel = 1'b1; end
      6'h0d: begin op_sel = ALU_OR;  src2_sel = SRC2_ZIMM; rd_src_sel = 1'b1; end
      6'h0e: begin op_sel = ALU_XOR; src2_sel = SRC2_ZIMM; rd_src_sel = 1'b1; end
`ifdef DECODE_LUI_EN
      6'h0f: begin op_sel = ALU_ADD; src2_sel = SRC2_UIMM; rd_src_sel = 1'b1; end
`endif
      default: legal = 1'b0;
    endcase
  end

  // Illegal encodings carry only their raw fields; all control bits stay zero.
  always_comb begin
    dec     = '0;
    dec.rs  = bus.in_inst[25:21];
    dec.rt  = bus.in_inst[20:16];
    dec.rd  = bus.in_inst[15:11];
    dec.imm = bus.in_inst[15:0];
    dec.tag = bus.in_tag;
    if (legal) begin
      dec.alu_op   = op_sel;
      dec.alu_src2 = src2_sel;
      dec.rd_src   = rd_src_sel;
      dec.we       = 1'b1;
    end else begin
      dec.except   = 1'b1;
    end
  end

  assign bus.in_ready  = (count != FULL_CNT);
  assign bus.out_valid = (count != '0);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem[wr_ptr] <= dec;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      exc_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push && dec.except && (exc_count != '1)) begin
        exc_count <= exc_count + 1'b1;
      end
    end
  end

  // Storage is never reset, so the empty case must force the head to zero.
  always_comb begin
    head = '0;
    if (count != '0) head = mem[rd_ptr];
  end

  assign bus.out_alu_op      = head.alu_op;
  assign bus.out_alu_src2    = head.alu_src2;
  assign bus.out_rd_src      = head.rd_src;
  assign bus.out_writeenable = head.we;
  assign bus.out_except      = head.except;
  assign bus.out_rs          = head.rs;
  assign bus.out_rt          = head.rt;
  assign bus.out_rd          = head.rd;
  assign bus.out_imm         = head.imm;
  assign bus.out_tag         = head.tag;
endmodule
